// File: rtl/allophone_queue_seq.sv
// allophone_queue_seq: FIFO feeder that hands 6-bit allophone codes to the Speech256 core one at a time.
// Optional macro ALLO_TIMEOUT_EN adds an ack timeout that abandons a code the core never accepts.
`default_nettype none

module allophone_queue_seq #(
    parameter int DEPTH_LOG2     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_an,
    input  logic [5:0]            wr_data,
    input  logic                  wr_stb,
    input  logic                  flush,
    input  logic                  enable,
    input  logic                  ldq,
    output logic [5:0]            data_out,
    output logic                  data_stb,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  overflow,
    output logic                  timeout_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_WAITACK = 2'b01
    } state_t;

    state_t                  state_q;
    logic [5:0]              mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic [DEPTH_LOG2:0]     count_d;
    logic [5:0]              data_out_q;
    logic                    data_stb_q;
    logic                    overflow_q;
    logic                    push;
    logic                    pop;

`ifdef ALLO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]           tmo_q;
    logic                    timeout_err_q;
`endif

    assign full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign busy  = !empty || (state_q != S_IDLE);

    // Fullness is judged on the registered count, so a pop in the same cycle never rescues a write.
    assign push = wr_stb && !full && !flush;
    assign pop  = (state_q == S_IDLE) && enable && ldq && !empty && !flush;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            data_stb_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ALLO_TIMEOUT_EN
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else if (flush) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_stb_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef ALLO_TIMEOUT_EN
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            if (wr_stb && full) begin
                overflow_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            data_stb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        data_out_q <= mem_q[rd_ptr_q];
                        data_stb_q <= 1'b1;
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                        state_q    <= S_WAITACK;
`ifdef ALLO_TIMEOUT_EN
                        tmo_q      <= '0;
`endif
                    end
                end
                S_WAITACK: begin
                    if (!ldq) begin
                        state_q <= S_IDLE;
                    end
`ifdef ALLO_TIMEOUT_EN
                    // The code counts as consumed on timeout; it is not re-issued.
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_q       <= S_IDLE;
                        timeout_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign count    = count_q;
    assign data_out = data_out_q;
    assign data_stb = data_stb_q;
    assign overflow = overflow_q;

`ifdef ALLO_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    // Always low; the expression only keeps TIMEOUT_CYCLES referenced in this build.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_allophone_queue_seq.sv
// tb_allophone_queue_seq: scoreboard bench for allophone_queue_seq with a simple ldq core model.
`default_nettype none

module tb_allophone_queue_seq;

    logic       clk;
    logic       rst_an;
    logic [5:0] wr_data;
    logic       wr_stb;
    logic       flush;
    logic       enable;
    logic       ldq;
    logic [5:0] data_out;
    logic       data_stb;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       busy;
    logic       overflow;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stb_count = 0;
    int stb_cyc = 0;
    bit stb_prev = 0;
    bit core_auto = 1;
    int hold_cycles = 10;
    int hold_left = 0;
    logic [5:0] exp_q [$];

    allophone_queue_seq #(
        .DEPTH_LOG2     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst_an      (rst_an),
        .wr_data     (wr_data),
        .wr_stb      (wr_stb),
        .flush       (flush),
        .enable      (enable),
        .ldq         (ldq),
        .data_out    (data_out),
        .data_stb    (data_stb),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .busy        (busy),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Caller is at a negedge; the write is presented across exactly one rising edge.
    task automatic wr(input logic [5:0] d, input bit accepted);
        if (accepted) exp_q.push_back(d);
        wr_data = d;
        wr_stb  = 1'b1;
        @(negedge clk);
        wr_stb  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string nm);
        int n;
        n = 0;
        while ((busy || !ldq) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy || !ldq) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", nm, max_cyc);
        end
    endtask

    // Monitor pops the scoreboard on every strobe; the core model answers with an ldq busy window.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (rst_an && data_stb) begin
                check("stb_after_ready", ldq, 1);
                check("stb_width", stb_prev, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_stb: got code 0x%0h, expected no strobe", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", data_out, e);
                end
                stb_count++;
                stb_cyc = cyc;
                if (core_auto) begin
                    ldq = 1'b0;
                    hold_left = hold_cycles;
                end
            end else if (core_auto && !ldq) begin
                if (hold_left <= 1) ldq = 1'b1;
                else hold_left--;
            end
            stb_prev = data_stb;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_an  = 1'b0;
        wr_data = '0;
        wr_stb  = 1'b0;
        flush   = 1'b0;
        enable  = 1'b1;
        ldq     = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_data_stb", data_stb, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout_err, 0);
        rst_an = 1'b1;
        @(negedge clk);

        // Single code: strobe one clock after the write edge, exactly one cycle wide.
        hold_cycles = 10;
        base = stb_count;
        wr(6'h2A, 1);
        check("t1_stb_not_yet", data_stb, 0);
        check("t1_count", count, 1);
        @(negedge clk);
        check("t1_stb_latency", data_stb, 1);
        @(negedge clk);
        check("t1_stb_low", data_stb, 0);
        wait_idle(50, "t1_idle");
        check("t1_empty", empty, 1);
        check("t1_nstb", stb_count - base, 1);

        // Three back-to-back codes paced by a 20-cycle busy window.
        hold_cycles = 20;
        base = stb_count;
        wr(6'h01, 1);
        wr(6'h02, 1);
        wr(6'h03, 1);
        check("t2_count", count, 2);
        wait_idle(200, "t2_idle");
        check("t2_nstb", stb_count - base, 3);
        check("t2_count_end", count, 0);

        // Fill with issue blocked, overflow on the 17th, then drain in order.
        enable = 1'b0;
        for (int i = 0; i < 16; i++) wr(6'h10 + 6'(i), 1);
        check("t3_full", full, 1);
        check("t3_count16", count, 16);
        check("t3_no_ovf", overflow, 0);
        wr(6'h3E, 0);
        check("t3_overflow", overflow, 1);
        check("t3_count_kept", count, 16);
        hold_cycles = 2;
        base = stb_count;
        enable = 1'b1;
        wait_idle(300, "t3_idle");
        check("t3_nstb", stb_count - base, 16);

        // Write and issue on the same edge with 8 queued, then keep feeding across the pointer wrap.
        enable = 1'b0;
        for (int i = 0; i < 8; i++) wr(6'h20 + 6'(i), 1);
        check("t4_count8", count, 8);
        hold_cycles = 3;
        base = stb_count;
        enable = 1'b1;
        wr(6'h28, 1);
        check("t4_count_same", count, 8);
        for (int i = 0; i < 8; i++) begin
            wr(6'h30 + 6'(i), 1);
            repeat (3) @(negedge clk);
        end
        wait_idle(300, "t4_idle");
        check("t4_nstb", stb_count - base, 17);

        // Flush with the FSM parked in S_WAITACK and five codes behind it.
        core_auto = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 6; i++) wr(6'h05 + 6'(i), 1);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_count5", count, 5);
        check("t5_busy", busy, 1);
        check("t5_ovf_sticky", overflow, 1);
        flush   = 1'b1;
        wr_stb  = 1'b1;
        wr_data = 6'h3F;
        @(negedge clk);
        flush  = 1'b0;
        wr_stb = 1'b0;
        exp_q.delete();
        check("t5_count0", count, 0);
        check("t5_empty", empty, 1);
        check("t5_busy_low", busy, 0);
        check("t5_ovf_clr", overflow, 0);
        base = stb_count;
        repeat (20) @(negedge clk);
        check("t5_no_stb", stb_count - base, 0);
        check("t5_count_still0", count, 0);

`ifdef ALLO_TIMEOUT_EN
        begin
            int n;
            int tstb;
            wr(6'h11, 1);
            wr(6'h12, 1);
            tstb = stb_cyc;
            n = 0;
            while (!timeout_err && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("t6_timeout_set", timeout_err, 1);
            check("t6_timeout_cycles", cyc - tstb, 100);
            @(negedge clk);
            check("t6_next_stb", data_stb, 1);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            exp_q.delete();
            check("t6_timeout_clr", timeout_err, 0);
        end
`else
        check("t6_timeout_tied", timeout_err, 0);
`endif
        core_auto = 1'b1;

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
